// File: rtl/ff_cacheline_adaptor_pkg.sv
// Shared constants and state encoding for the cache-line <-> memory-burst adaptor.
// The cache and the memory model pull the same widths from here.
package ff_cacheline_adaptor_pkg;

   localparam int LINE_W     = 256;
   localparam int BURST_W    = 64;
   localparam int BEATS      = LINE_W / BURST_W;
   localparam int LINE_OFF_W = 5;   // log2(LINE_W/8): byte offset inside a line

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } adaptor_state_t;

endpackage

// File: rtl/ff_cacheline_adaptor.sv
// Turns one 256-bit line fill/writeback from the cache into a burst of
// 64-bit beats on the memory bus and returns a single-cycle line response.
// Every output is a register or a decode of the state register.
module ff_cacheline_adaptor #(
   parameter int LINE_W  = ff_cacheline_adaptor_pkg::LINE_W,
   parameter int BURST_W = ff_cacheline_adaptor_pkg::BURST_W,
   parameter int ADDR_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   line_address_i,
   input  logic                line_read_i,
   input  logic                line_write_i,
   input  logic [LINE_W-1:0]   line_wdata_i,
   output logic [LINE_W-1:0]   line_rdata_o,
   output logic                line_resp_o,
   output logic [ADDR_W-1:0]   burst_address_o,
   output logic                burst_read_o,
   output logic                burst_write_o,
   output logic [BURST_W-1:0]  burst_wdata_o,
   input  logic [BURST_W-1:0]  burst_rdata_i,
   input  logic                burst_resp_i
);

   import ff_cacheline_adaptor_pkg::*;

   localparam int NBEATS = LINE_W / BURST_W;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

   adaptor_state_t      state_q, state_d;
   logic [BEAT_W-1:0]   beat_q,  beat_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [LINE_W-1:0]   wbuf_q,  wbuf_d;
   logic [LINE_W-1:0]   rbuf_q,  rbuf_d;

   // Next-state: request capture in IDLE, one beat per memory ack in READ/WRITE.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      wbuf_d  = wbuf_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         IDLE: begin
            // Write wins when both requests are up.
            if (line_write_i || line_read_i) begin
               addr_d  = {line_address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               beat_d  = '0;
               state_d = line_write_i ? WRITE : READ;
               if (line_write_i) wbuf_d = line_wdata_i;
            end
         end
         READ: begin
            if (burst_resp_i) begin
               rbuf_d[beat_q*BURST_W +: BURST_W] = burst_rdata_i;
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = DONE;
            end
         end
         WRITE: begin
            if (burst_resp_i) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
      end
   end

   assign line_rdata_o    = rbuf_q;
   assign line_resp_o     = (state_q == DONE);
   assign burst_read_o    = (state_q == READ);
   assign burst_write_o   = (state_q == WRITE);
   assign burst_address_o = addr_q;
   assign burst_wdata_o   = wbuf_q[beat_q*BURST_W +: BURST_W];

endmodule
